// File: rtl/calc_pkg.sv
// calc_pkg: command codes shared with calc_top, keypad FSM states, key map.
// Latency: n/a (declarations and a pure combinational helper only).
// Backpressure: n/a.
package calc_pkg;

   localparam logic [3:0] CMD_ADD  = 4'b1010;
   localparam logic [3:0] CMD_SUB  = 4'b1011;
   localparam logic [3:0] CMD_MUL  = 4'b1100;
   localparam logic [3:0] CMD_CLR  = 4'b1101;
   localparam logic [3:0] CMD_EQ   = 4'b1110;
   localparam logic [3:0] CMD_IDLE = 4'b1111;

   // Prefixed so the DEBOUNCE state cannot collide with the DEBOUNCE
   // parameter of calc_keypad once this package is wildcard-imported.
   typedef enum logic [1:0] {
      S_SCAN,
      S_DEBOUNCE,
      S_PRESSED
   } kp_state_t;

   // Physical key position -> command code. The unused key (r3, c3)
   // maps to CMD_IDLE, which callers treat as "no key".
   function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      if (row == 2'd3) begin
         case (col)
            2'd0:    code = CMD_CLR;
            2'd1:    code = 4'd0;
            2'd2:    code = CMD_EQ;
            default: code = CMD_IDLE;
         endcase
      end else if (col == 2'd3) begin
         code = CMD_ADD + {2'b00, row};
      end else begin
         code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
      end
      return code;
   endfunction

endpackage

// File: rtl/calc_key_encode.sv
// calc_key_encode: rows + column index -> command code, lowest row wins.
// Latency: combinational.
// Backpressure: none.
// Ports: rows (row sense), col (driven column index), code (mapped command,
//        CMD_IDLE when nothing usable), hit (a usable key is closed).
module calc_key_encode
   import calc_pkg::*;
(
   input  logic [3:0] rows,
   input  logic [1:0] col,
   output logic [3:0] code,
   output logic       hit
);

   always_comb begin
      code = CMD_IDLE;
      if      (rows[0]) code = key_code(2'd0, col);
      else if (rows[1]) code = key_code(2'd1, col);
      else if (rows[2]) code = key_code(2'd2, col);
      else if (rows[3]) code = key_code(2'd3, col);
      // Only the unused key maps to CMD_IDLE, so this blanks it as well.
      hit = (code != CMD_IDLE);
   end

endmodule

// File: rtl/calc_keypad.sv
// calc_keypad: 4x4 matrix scanner + debouncer producing calc_top commands.
// Latency: cmd/cmd_valid 1+(DEBOUNCE-1)*SCAN_DIV cycles after first sample.
// Backpressure: none; cmd holds for the press, cmd_valid pulses once.
// Ports: clock, reset (sync, active-high), rows (row sense), cols (one-hot
//        column drive), cmd (code, 1111 idle), cmd_valid (new-code strobe),
//        key_held (debounced key down).
module calc_keypad
   import calc_pkg::*;
#(
   parameter int SCAN_DIV = 4,
   parameter int DEBOUNCE = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic [3:0] cmd,
   output logic       cmd_valid,
   output logic       key_held
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   // A count equal to this means the current sample is the last one needed.
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

   kp_state_t     state_q, state_nx;
   logic [DW-1:0] div_q;
   logic [1:0]    col_q, col_nx;
   logic [CW-1:0] cnt_q, cnt_nx;
   logic [CW-1:0] rel_q, rel_nx;
   logic [3:0]    code_q, code_nx;
   logic [3:0]    cmd_nx;
   logic          vld_nx, held_nx;
   logic          sample;
   logic [3:0]    enc_code;
   logic          enc_hit;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == CW'(DEBOUNCE)) ? v : v + 1'b1;
   endfunction

   assign sample = (div_q == DIV_LAST);

   calc_key_encode u_encode (
      .rows (rows),
      .col  (col_q),
      .code (enc_code),
      .hit  (enc_hit)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_SCAN;
         div_q     <= '0;
         col_q     <= 2'd0;
         cols      <= 4'b0001;
         cnt_q     <= '0;
         rel_q     <= '0;
         code_q    <= CMD_IDLE;
         cmd       <= CMD_IDLE;
         cmd_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         state_q   <= state_nx;
         div_q     <= sample ? '0 : div_q + 1'b1;
         col_q     <= col_nx;
         cols      <= 4'b0001 << col_nx;
         cnt_q     <= cnt_nx;
         rel_q     <= rel_nx;
         code_q    <= code_nx;
         cmd       <= cmd_nx;
         cmd_valid <= vld_nx;
         key_held  <= held_nx;
      end
   end

   // Everything only moves on a sample cycle; in between the column and
   // all counters hold. The column advances exactly when we (re)enter or
   // stay in SCAN, and is frozen otherwise.
   always_comb begin
      state_nx = state_q;
      col_nx   = col_q;
      cnt_nx   = cnt_q;
      rel_nx   = rel_q;
      code_nx  = code_q;
      cmd_nx   = cmd;
      vld_nx   = 1'b0;
      held_nx  = key_held;
      if (sample) begin
         unique case (state_q)
            S_SCAN: begin
               if (enc_hit) begin
                  code_nx = enc_code;
                  if (DEBOUNCE == 1) begin
                     state_nx = S_PRESSED;
                     cmd_nx   = enc_code;
                     vld_nx   = 1'b1;
                     held_nx  = 1'b1;
                     cnt_nx   = '0;
                  end else begin
                     state_nx = S_DEBOUNCE;
                     cnt_nx   = CW'(1);
                  end
               end else begin
                  col_nx = col_q + 2'd1;
               end
            end
            S_DEBOUNCE: begin
               // Column is frozen, so an identical code means the same row.
               if (enc_hit && enc_code == code_q) begin
                  if (cnt_q == CNT_LAST) begin
                     state_nx = S_PRESSED;
                     cmd_nx   = code_q;
                     vld_nx   = 1'b1;
                     held_nx  = 1'b1;
                     cnt_nx   = '0;
                  end else begin
                     cnt_nx = sat_inc(cnt_q);
                  end
               end else begin
                  state_nx = S_SCAN;
                  cnt_nx   = '0;
                  col_nx   = col_q + 2'd1;
               end
            end
            S_PRESSED: begin
               if (rows == 4'b0000) begin
                  if (rel_q == CNT_LAST) begin
                     state_nx = S_SCAN;
                     cmd_nx   = CMD_IDLE;
                     held_nx  = 1'b0;
                     rel_nx   = '0;
                     col_nx   = col_q + 2'd1;
                  end else begin
                     rel_nx = sat_inc(rel_q);
                  end
               end else begin
                  rel_nx = '0;
               end
            end
            default: state_nx = S_SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_keypad.sv
// tb_calc_keypad: scenario checks plus randomized presses for calc_keypad.
// Latency: n/a (bench).
// Backpressure: n/a.
module tb_calc_keypad;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] rows  = 4'b0000;
   logic [3:0] cols;
   logic [3:0] cmd;
   logic       cmd_valid;
   logic       key_held;

   calc_keypad #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
      .clock     (clock),
      .reset     (reset),
      .rows      (rows),
      .cols      (cols),
      .cmd       (cmd),
      .cmd_valid (cmd_valid),
      .key_held  (key_held)
   );

   always #5 clock = ~clock;

   // 1 + (DEBOUNCE-1)*SCAN_DIV with the default parameters.
   localparam int LAT = 9;

   // Key map indexed by row*4+col; 4'hF marks the unused position.
   logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                             4'h4, 4'h5, 4'h6, 4'hB,
                             4'h7, 4'h8, 4'h9, 4'hC,
                             4'hD, 4'h0, 4'hE, 4'hF};

   logic [15:0] pressed = '0;   // physical key state, bit row*4+col
   int          cyc;            // cycle number since last reset release
   int          first_nz;       // first sample cycle with nonzero rows
   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [3:0]  ev_code [$];
   int          ev_cyc  [$];

   task automatic clear_log();
      ev_code.delete();
      ev_cyc.delete();
      first_nz = -1;
   endtask

   // Present the matrix for the current cycle from the driven column, then
   // move to the next falling edge and log any strobe seen there.
   task automatic advance();
      for (int r = 0; r < 4; r++) rows[r] = |(pressed[r*4 +: 4] & cols);
      if (rows != 4'b0000 && (cyc % 4) == 3 && first_nz < 0) first_nz = cyc;
      @(posedge clock);
      @(negedge clock);
      cyc++;
      if (cmd_valid) begin
         ev_code.push_back(cmd);
         ev_cyc.push_back(cyc);
      end
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      rows  = 4'b0000;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      cyc   = 0;
      clear_log();
   endtask

   task automatic test_reset();
      pressed = '0;
      reset_dut();
      n_cmp++;
      if (cmd !== 4'hF || cmd_valid !== 1'b0 || key_held !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: cmd=%h valid=%b held=%b, want cmd=f valid=0 held=0",
                  cmd, cmd_valid, key_held);
      end
      for (int i = 0; i < 20; i++) begin
         logic [3:0] exp_cols;
         exp_cols = 4'b0001 << ((i / 4) % 4);
         n_cmp++;
         if (cols !== exp_cols) begin
            n_fail++;
            $display("FAIL reset_rotation: cycle %0d cols=%b, want %b", i, cols, exp_cols);
         end
         advance();
      end
   endtask

   task automatic test_press_two();
      reset_dut();
      pressed = 16'h0002;
      for (int i = 0; i <= 60; i++) begin
         logic [3:0] exp_cmd, exp_cols;
         logic       exp_vld, exp_held;
         exp_held = (i >= 16 && i < 52);
         exp_cmd  = exp_held ? 4'h2 : 4'hF;
         exp_vld  = (i == 16);
         if      (i < 4)  exp_cols = 4'b0001;
         else if (i < 52) exp_cols = 4'b0010;
         else if (i < 56) exp_cols = 4'b0100;
         else if (i < 60) exp_cols = 4'b1000;
         else             exp_cols = 4'b0001;
         n_cmp++;
         if ({cols, cmd, cmd_valid, key_held} !== {exp_cols, exp_cmd, exp_vld, exp_held}) begin
            n_fail++;
            $display("FAIL press_two: cycle %0d cols=%b cmd=%h valid=%b held=%b, want cols=%b cmd=%h valid=%b held=%b",
                     i, cols, cmd, cmd_valid, key_held, exp_cols, exp_cmd, exp_vld, exp_held);
         end
         if (i == 40) pressed = '0;
         advance();
      end
      pressed = '0;
   endtask

   task automatic test_sequence();
      int         keys [4] = '{0, 3, 2, 14};
      logic [3:0] want [4] = '{4'h1, 4'hA, 4'h3, 4'hE};
      clear_log();
      for (int j = 0; j < 4; j++) begin
         pressed = 16'd1 << keys[j];
         repeat (50) advance();
         pressed = '0;
         repeat (50) advance();
      end
      n_cmp++;
      if (ev_code.size() != 4) begin
         n_fail++;
         $display("FAIL sequence_count: got %0d strobes, want 4", ev_code.size());
      end else begin
         for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (ev_code[j] !== want[j]) begin
               n_fail++;
               $display("FAIL sequence_code: strobe %0d cmd=%h, want %h", j, ev_code[j], want[j]);
            end
         end
      end
   endtask

   task automatic test_bounce();
      reset_dut();
      pressed = 16'h0010;              // r1c0 seen by the cycle-3 sample only
      repeat (4) advance();
      pressed = '0;
      for (int i = 4; i < 40; i++) begin
         logic [3:0] exp_cols;
         if      (i < 8)  exp_cols = 4'b0001;
         else if (i < 12) exp_cols = 4'b0010;
         else if (i < 16) exp_cols = 4'b0100;
         else             exp_cols = 4'b0001 << (((i - 4) / 4) % 4);
         n_cmp++;
         if (cols !== exp_cols) begin
            n_fail++;
            $display("FAIL bounce_cols: cycle %0d cols=%b, want %b", i, cols, exp_cols);
         end
         advance();
      end
      n_cmp++;
      if (ev_code.size() != 0 || key_held !== 1'b0) begin
         n_fail++;
         $display("FAIL bounce_emit: strobes=%0d held=%b, want 0 and 0", ev_code.size(), key_held);
      end

      reset_dut();
      pressed = 16'h0110;              // r1c0 and r2c0 together
      repeat (21) advance();
      n_cmp++;
      if (ev_code.size() != 1) begin
         n_fail++;
         $display("FAIL multirow_count: got %0d strobes, want 1", ev_code.size());
      end else begin
         n_cmp++;
         if (ev_code[0] !== 4'h4 || ev_cyc[0] != 12) begin
            n_fail++;
            $display("FAIL multirow_code: cmd=%h at cycle %0d, want 4 at 12", ev_code[0], ev_cyc[0]);
         end
      end
      n_cmp++;
      if (cmd !== 4'h4 || key_held !== 1'b1) begin
         n_fail++;
         $display("FAIL multirow_hold: cmd=%h held=%b, want 4 and 1", cmd, key_held);
      end
      pressed = '0;
   endtask

   task automatic test_unused();
      reset_dut();
      pressed = 16'h8000;
      repeat (100) advance();
      n_cmp++;
      if (ev_code.size() != 0 || key_held !== 1'b0 || cmd !== 4'hF) begin
         n_fail++;
         $display("FAIL unused_key: strobes=%0d held=%b cmd=%h, want 0, 0, f",
                  ev_code.size(), key_held, cmd);
      end
      n_cmp++;
      if (cols !== 4'b0010) begin
         n_fail++;
         $display("FAIL unused_rotation: cycle 100 cols=%b, want 0010", cols);
      end
      pressed = '0;
   endtask

   task automatic test_reset_midpress();
      reset_dut();
      pressed = 16'h0020;              // "5" at r1c1
      repeat (30) advance();
      n_cmp++;
      if (cmd !== 4'h5 || key_held !== 1'b1 || ev_code.size() != 1) begin
         n_fail++;
         $display("FAIL midpress_before: cmd=%h held=%b strobes=%0d, want 5, 1, 1",
                  cmd, key_held, ev_code.size());
      end
      reset = 1'b1;
      advance();
      n_cmp++;
      if (cmd !== 4'hF || key_held !== 1'b0 || cmd_valid !== 1'b0 || cols !== 4'b0001) begin
         n_fail++;
         $display("FAIL midpress_reset: cmd=%h held=%b valid=%b cols=%b, want f, 0, 0, 0001",
                  cmd, key_held, cmd_valid, cols);
      end
      reset = 1'b0;
      cyc   = 0;
      clear_log();
      repeat (30) advance();
      n_cmp++;
      if (ev_code.size() != 1) begin
         n_fail++;
         $display("FAIL midpress_redetect_count: got %0d strobes, want 1", ev_code.size());
      end else begin
         n_cmp++;
         if (ev_code[0] !== 4'h5 || ev_cyc[0] != 16) begin
            n_fail++;
            $display("FAIL midpress_redetect: cmd=%h at cycle %0d, want 5 at 16", ev_code[0], ev_cyc[0]);
         end
      end
      pressed = '0;
   endtask

   task automatic test_random();
      reset_dut();
      repeat (20) advance();
      for (int n = 0; n < 12; n++) begin
         int   k, c, hold, gap, t_rel, z;
         logic usable;
         k = (n == 5) ? 15 : $urandom_range(0, 15);
         c = k % 4;
         usable = (kmap[k] != 4'hF);
         clear_log();
         pressed = 16'd1 << k;
         hold = $urandom_range(40, 70);
         repeat (hold) advance();
         n_cmp++;
         if (usable) begin
            if (ev_code.size() != 1 || ev_code[0] !== kmap[k] || ev_cyc[0] != first_nz + LAT
                || cmd !== kmap[k] || key_held !== 1'b1) begin
               n_fail++;
               $display("FAIL random_press: key %0d strobes=%0d code=%h at %0d cmd=%h held=%b, want 1 strobe %h at %0d",
                        k, ev_code.size(), (ev_code.size() > 0) ? ev_code[0] : 4'hx,
                        (ev_cyc.size() > 0) ? ev_cyc[0] : -1, cmd, key_held, kmap[k], first_nz + LAT);
            end
         end else if (ev_code.size() != 0 || key_held !== 1'b0) begin
            n_fail++;
            $display("FAIL random_unused: key %0d strobes=%0d held=%b, want 0 and 0",
                     k, ev_code.size(), key_held);
         end
         pressed = '0;
         t_rel = cyc;
         z = t_rel + (3 - (t_rel % 4));
         if (usable) begin
            while (cyc < z + LAT - 1) advance();
            n_cmp++;
            if (cmd !== kmap[k]) begin
               n_fail++;
               $display("FAIL random_release_early: cycle %0d cmd=%h, want %h", cyc, cmd, kmap[k]);
            end
            advance();
            n_cmp++;
            if (cmd !== 4'hF || key_held !== 1'b0 || cols !== (4'b0001 << ((c + 1) % 4))) begin
               n_fail++;
               $display("FAIL random_release: cycle %0d cmd=%h held=%b cols=%b, want f, 0, %b",
                        cyc, cmd, key_held, cols, 4'b0001 << ((c + 1) % 4));
            end
         end
         gap = $urandom_range(20, 50);
         repeat (gap) advance();
         n_cmp++;
         if (ev_code.size() != (usable ? 1 : 0)) begin
            n_fail++;
            $display("FAIL random_once: key %0d strobes=%0d, want %0d", k, ev_code.size(), usable ? 1 : 0);
         end
      end
   endtask

   initial begin
      cyc      = 0;
      first_nz = -1;
      test_reset();
      test_press_two();
      test_sequence();
      test_bounce();
      test_unused();
      test_reset_midpress();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/calc_keypad.md
# calc_keypad

Matrix-keypad front end for the calculator: it scans a 4×4 key matrix, debounces presses and transmits 4-bit command codes on the `cmd` input of `calc_top`. `calc_top` consumes these codes: digits, operators, clear and equals. `calc_keypad` sits between the board keypad pins and `calc_top`, and replaces the directly driven `cmd` stimulus. The output holds a valid code for the whole press, plus a one-cycle strobe, and returns to an idle code on release.

## Interface
- `SCAN_DIV`, default 4: clock cycles each column is driven; must be ≥2.
- `DEBOUNCE`, default 3: consecutive matching samples required for press and for release; must be ≥1.
- `clock`  in  1: single system clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `rows`  in  4: matrix row sense; bit r=1 means a key in row r of the driven column is closed.
- `cols`  out  4: one-hot column drive, active-high.
- `cmd`  out  4: command code to `calc_top`; `4'b1111` = idle.
- `cmd_valid`  out  1: one-cycle pulse when a new debounced code appears on `cmd`.
- `key_held`  out  1: high while a debounced key is pressed.

## Operation
- Key map (row r, col c):
  - r0: 1, 2, 3, ADD `1010`
  - r1: 4, 5, 6, SUB `1011`
  - r2: 7, 8, 9, MUL `1100`
  - r3: CLR `1101`, 0, EQ `1110`, unused
- The unused key (r3, c3) is treated as no key.
- Divider counter `div` counts 0..SCAN_DIV-1. The sample cycle is `div==SCAN_DIV-1`. Only sample cycles evaluate `rows`.
- If several rows are set, the lowest row index wins.
- SCAN state:
  - `cols` rotates 0001→0010→0100→1000→0001, advancing on the cycle after each sample cycle.
  - On a sample with a valid key: latch (row, col), set match count to 1, freeze `cols`, go to DEBOUNCE.
- DEBOUNCE state:
  - Each sample either matches the latched row (count+1) or does not (no key, or a different lowest row).
  - On a mismatch, return to SCAN and resume rotation at the next column.
  - When count reaches DEBOUNCE, go to PRESSED. `cmd` takes the mapped code and `cmd_valid` pulses.
  - If DEBOUNCE=1, the detecting sample itself completes the debounce.
- PRESSED state:
  - `cols` stays frozen, `key_held`=1, and `cmd` holds the code.
  - Samples with `rows`==0 increment a release count. Any nonzero sample clears the release count; a different row does not change `cmd`.
  - When the release count reaches DEBOUNCE: `cmd`=1111, `key_held`=0, go to SCAN, and resume rotation at the next column.
- A key is emitted once per press; there is no auto-repeat.

## Timing
- Reset values: `cols`=0001, `cmd`=1111, `cmd_valid`=0, `key_held`=0, state SCAN, all counters 0.
- Reset mid-press restarts scanning. A key still held is re-detected and re-emitted after a full debounce.
- All outputs are registered. `cmd`, `cmd_valid` and `key_held` update the cycle after the deciding sample.
- Press latency: a key stable from its first sample emits `cmd_valid` 1 + (DEBOUNCE-1)·SCAN_DIV cycles after that sample. With defaults this is 9 cycles.
- Release latency: `cmd` returns to 1111 1 + (DEBOUNCE-1)·SCAN_DIV cycles after the first zero sample.
- `cmd_valid` is never high on two consecutive cycles.
- `cmd` changes only at press-accept (idle→code) and at release (code→idle).
- Counter widths: `div` is $clog2(SCAN_DIV) bits; the match and release counters are $clog2(DEBOUNCE+1) bits each. Counters saturate and never wrap.

## Structure
- `calc_pkg` holds:
  - command constants `CMD_ADD`, `CMD_SUB`, `CMD_MUL`, `CMD_CLR`, `CMD_EQ`, `CMD_IDLE`;
  - the keypad state enum (`SCAN`, `DEBOUNCE`, `PRESSED`);
  - the row/col→cmd map function.
- `calc_top` imports the same command constants.
- Sub-module `calc_key_encode` is combinational. It takes the 4-bit `rows` and a 2-bit column index and outputs a 4-bit code plus a `hit` signal, applying lowest-row priority and blanking the unused key.
- The FSM, divider and counters live in `calc_keypad`.

## Test plan
All scenarios use defaults. Cycle 0 is the first edge after reset deasserts; column 1 is driven during cycles 4–7.
- Reset → `cols`=0001, `cmd`=1111, `cmd_valid`=0; `cols` shows the rotation 0001, 0010, 0100, 1000, 0001 at cycles 0, 4, 8, 12, 16.
- Hold r0c1 ("2") from cycle 0 → samples at 7, 11, 15; `cmd_valid` pulses at 16 with `cmd`=2; `key_held`=1.
- Release "2" at cycle 40 → `cmd`=1111 and `key_held`=0 nine cycles after the first zero sample; scanning resumes at `cols`=0100.
- Drive "1", ADD, "3", EQ as separate presses → the `cmd_valid`-qualified codes are exactly 0001, 1010, 0011, 1110, each emitted once.
- Bounce: r1c0 present for one sample, then absent → no `cmd_valid`, and scanning continues at column 1; r1c0 and r2c0 together → `cmd`=4.
- Hold r3c3 → no `cmd_valid` ever. Assert `reset` while "5" is held (PRESSED) → `cmd`=1111 next cycle, followed by a fresh detection and emission of 0101.
